// File: rtl/i2s_receiver.sv
// I2S receiver: synchronizes bclk/lrclk/sdata into clk, deserializes left/right words
// and presents each completed pair on a valid/ready handshake with a sticky overrun flag.
module i2s_receiver #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             bclk,
    input  logic             lrclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_q, lrclk_sync_q, sdata_sync_q;
    logic                   bclk_d_q;
    logic                   bclk_s, lrclk_s, sdata_s;
    logic                   rise, change, load;

    state_t                 state_q, state_d;
    logic                   ws_prev_q, ws_prev_d;
    logic                   primed_q, primed_d;
    logic [CW-1:0]          count_q, count_d, count_shift;
    logic [WIDTH-1:0]       shreg_q, shreg_d, shreg_shift, committed;
    logic [WIDTH-1:0]       left_hold_q, left_hold_d;
    logic [WIDTH-1:0]       left_q, left_d, right_q, right_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;

    assign bclk_s  = bclk_sync_q[SYNC_STAGES-1];
    assign lrclk_s = lrclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdata_sync_q <= '0;
            bclk_d_q     <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], lrclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
            bclk_d_q     <= bclk_s;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= HUNT;
            ws_prev_q   <= 1'b0;
            primed_q    <= 1'b0;
            count_q     <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ws_prev_q   <= ws_prev_d;
            primed_q    <= primed_d;
            count_q     <= count_d;
            shreg_q     <= shreg_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // The bit captured on the word-select change rise still belongs to the closing word.
    always_comb begin
        rise        = bclk_s & ~bclk_d_q;
        shreg_shift = shreg_q;
        count_shift = count_q;
        if (count_q < CW'(WIDTH)) begin
            shreg_shift = {shreg_q[WIDTH-2:0], sdata_s};
            count_shift = count_q + CW'(1);
        end
        committed = shreg_shift << (CW'(WIDTH) - count_shift);
        change    = rise & primed_q & (lrclk_s != ws_prev_q);
    end

    always_comb begin
        state_d     = state_q;
        ws_prev_d   = ws_prev_q;
        primed_d    = primed_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        left_hold_d = left_hold_q;
        load        = 1'b0;

        if (rise) begin
            ws_prev_d = lrclk_s;
            primed_d  = 1'b1;
            if (change) begin
                shreg_d = '0;
                count_d = '0;
            end else begin
                shreg_d = shreg_shift;
                count_d = count_shift;
            end
        end

        if (change) begin
            case (state_q)
                HUNT: begin
                    if (!lrclk_s) state_d = LEFT;
                end
                LEFT: begin
                    left_hold_d = committed;
                    state_d     = RIGHT;
                end
                RIGHT: begin
                    load    = 1'b1;
                    state_d = LEFT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // A pair arriving while the previous one is still unclaimed overwrites it and sets overrun.
    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (clr_ovr) overrun_d = 1'b0;

        if (load) begin
            left_d  = left_hold_q;
            right_d = committed;
            valid_d = 1'b1;
            if (valid_q && !ready) overrun_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    assign left_data  = left_q;
    assign right_data = right_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;

endmodule
